// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - sequential radix-2 Booth multiplier, WIDTH-bit operands, signed/unsigned per op.
// Optional accumulate mode enabled by defining BOOTH_MAC_EN (adds acc_en input).
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
`ifdef BOOTH_MAC_EN
    input  logic                 acc_en,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int E  = WIDTH + 1;
    localparam int CW = $clog2(E + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [E-1:0]         acc_q, acc_d;
    logic [E-1:0]         m_q, m_d;
    logic [E-1:0]         q_q, q_d;
    logic                 q1_q, q1_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [E-1:0]         sum;
    logic [2*WIDTH-1:0]   mul_res;
`ifdef BOOTH_MAC_EN
    logic                 mac_q, mac_d;
`endif

    // Low 2*WIDTH bits of {acc, multiplier}; the top two acc bits are only sign copies.
    assign mul_res = {acc_q[WIDTH-2:0], q_q};

    always_comb begin
        sum = acc_q;
        case ({q_q[0], q1_q})
            2'b10:   sum = acc_q - m_q;
            2'b01:   sum = acc_q + m_q;
            default: sum = acc_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        m_d     = m_q;
        q_d     = q_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        done_d  = 1'b0;
        busy_d  = (state_q == RUN);
`ifdef BOOTH_MAC_EN
        mac_d   = mac_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = is_signed ? {b[WIDTH-1], b} : {1'b0, b};
                    q_d     = is_signed ? {a[WIDTH-1], a} : {1'b0, a};
                    acc_d   = '0;
                    q1_d    = 1'b0;
                    cnt_d   = CW'(E);
`ifdef BOOTH_MAC_EN
                    mac_d   = acc_en;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    {acc_d, q_d, q1_d} = {sum[E-1], sum, q_q};
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
`ifdef BOOTH_MAC_EN
                prod_d = mac_q ? (prod_q + mul_res) : mul_res;
`else
                prod_d = mul_res;
`endif
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            m_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            prod_q  <= '0;
`ifdef BOOTH_MAC_EN
            mac_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            prod_q  <= prod_d;
`ifdef BOOTH_MAC_EN
            mac_q   <= mac_d;
`endif
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = prod_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb/tb_booth_mult_seq.sv - directed bench for booth_mult_seq with a product scoreboard.
module tb_booth_mult_seq;
    localparam int W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             is_signed;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
`ifdef BOOTH_MAC_EN
    logic             acc_en;
`endif
    logic             busy;
    logic             done;
    logic [2*W-1:0]   product;

    int               tests = 0;
    int               fails = 0;
    logic [2*W-1:0]   exp_q[$];
    logic [2*W-1:0]   run_sum;

    always #5 clk = ~clk;

    booth_mult_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
`ifdef BOOTH_MAC_EN
        .acc_en    (acc_en),
`endif
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [2*W-1:0] mul_ref(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic s);
        longint px, py;
        px = s ? longint'($signed(x)) : longint'(x);
        py = s ? longint'($signed(y)) : longint'(y);
        return (2*W)'(px * py);
    endfunction

    // Drives a start request at a negedge and pushes the expected product.
    task automatic drive(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is,
                         input logic iacc);
        logic [2*W-1:0] e;
        a = ia;
        b = ib;
        is_signed = is;
        start = 1'b1;
`ifdef BOOTH_MAC_EN
        acc_en = iacc;
`endif
        e = iacc ? (run_sum + mul_ref(ia, ib, is)) : mul_ref(ia, ib, is);
        run_sum = e;
        exp_q.push_back(e);
    endtask

    // Called at the negedge j0 cycles after the accepting edge; returns in the done cycle.
    task automatic wait_done(input string tag, input int j0, input int exp_lat, input int exp_busy);
        int lat;
        int bc;
        lat = -1;
        bc = 0;
        for (int j = j0; j < j0 + 40; j++) begin
            if (busy === 1'b1) bc++;
            if (done === 1'b1) begin
                lat = j;
                break;
            end
            @(negedge clk);
        end
        chk({tag, " latency"}, lat, exp_lat);
        if (exp_busy >= 0) chk({tag, " busy cycles"}, bc, exp_busy);
        chk({tag, " scoreboard depth"}, exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            if (lat >= 0) chk({tag, " product"}, product, exp_q.pop_front());
            else void'(exp_q.pop_front());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_sum = '0;
        exp_q.delete();
    endtask

    initial begin
        logic [W-1:0] ta [9];
        logic [W-1:0] tb [9];
        logic         ts [9];
        int           dcnt;

        ta = '{8'hFF, 8'hFF, 8'h80, 8'h80, 8'h00, 8'hFF, 8'h7F, 8'h01, 8'hC3};
        tb = '{8'hFF, 8'hFF, 8'h80, 8'h7F, 8'hFF, 8'h80, 8'h80, 8'h01, 8'h5A};
        ts = '{1'b0,  1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};

        rst = 1'b1;
        start = 1'b0;
        is_signed = 1'b0;
        a = '0;
        b = '0;
        run_sum = '0;
`ifdef BOOTH_MAC_EN
        acc_en = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset product", product, 0);
        rst = 1'b0;

        // -7 x 5 signed: latency and busy width
        @(negedge clk);
        drive(8'hF9, 8'h05, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_done("m7x5", 0, 11, 10);
        chk("m7x5 literal", product, 16'hFFDD);
        @(negedge clk);
        chk("m7x5 done pulse", done, 0);
        chk("m7x5 product held", product, 16'hFFDD);

        // Corner and mixed-mode pairs
        for (int i = 0; i < 9; i++) begin
            drive(ta[i], tb[i], ts[i], 1'b0);
            @(negedge clk);
            start = 1'b0;
            wait_done($sformatf("pair%0d", i), 0, 11, 10);
        end

        for (int i = 0; i < 6; i++) begin
            drive(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            @(negedge clk);
            start = 1'b0;
            wait_done($sformatf("rand%0d", i), 0, 11, 10);
        end

        // Start during RUN ignored; operand changes ignored; back-to-back issue in done cycle
        drive(8'h12, 8'hFD, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        a = 8'h55;
        b = 8'h66;
        is_signed = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'hAA;
        b = 8'h33;
        wait_done("ignored start", 4, 11, -1);
        drive(8'h9C, 8'h27, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_done("back to back", 0, 11, 10);

        // Reset during RUN aborts the operation
        @(negedge clk);
        drive(8'h2B, 8'h11, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_sum = '0;
        exp_q.delete();
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort product", product, 0);
        dcnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (done === 1'b1) dcnt++;
            @(negedge clk);
        end
        chk("abort no done", dcnt, 0);
        drive(8'hE0, 8'h0B, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_done("after abort", 0, 11, 10);

`ifdef BOOTH_MAC_EN
        do_reset();
        drive(8'd3, 8'd4, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_done("mac 3x4", 0, 11, 10);
        chk("mac 3x4 literal", product, 16'd12);
        drive(8'd2, 8'd5, 1'b1, 1'b1);
        @(negedge clk);
        start = 1'b0;
        wait_done("mac 2x5", 0, 11, 10);
        chk("mac 2x5 literal", product, 16'd22);
        drive(8'hFF, 8'd30, 1'b1, 1'b1);
        @(negedge clk);
        start = 1'b0;
        wait_done("mac m1x30", 0, 11, 10);
        chk("mac m1x30 literal", product, 16'hFFF8);
        do_reset();
        chk("mac reset product", product, 0);
`else
        do_reset();
        chk("final reset product", product, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
